// File: rtl/serial_frame_tx_if.sv
// Bus bundle for serial_frame_tx: the board switches in, the LEDs out.
interface serial_frame_tx_if;
    logic [9:0] SW;
    logic [9:0] LEDR;

    modport master (output SW, input LEDR);
    modport slave  (input SW, output LEDR);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: latches a DATA_W-bit word from SW and shifts it out on
// LEDR[0] one bit per KEY[0] edge as start(0), data LSB first, stop(1).
// SW[9] is a synchronous active-high reset, SW[8] a start request (rising).
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit.
module serial_frame_tx #(
    parameter int DATA_W = 8
) (
    input logic [0:0]         KEY,
    serial_frame_tx_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

    logic              rst;
    logic              start_req;
    logic [DATA_W-1:0] din;
    logic              rise;

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        index;
    logic              line;
    logic              busy;
    logic              done;
    logic              start_prev;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              par;
`endif

    assign rst       = bus.SW[9];
    assign start_req = bus.SW[8];
    assign din       = bus.SW[DATA_W-1:0];
    assign rise      = start_req & ~start_prev;

    // Every LED comes straight from a register; the unused middle bits are tied low.
    assign bus.LEDR = {busy, done, 4'b0000, index, line};

    // Frame sequencer. The STOP edge doubles as an IDLE edge so a start
    // request arriving together with done launches the next frame at once.
    always_ff @(posedge KEY[0]) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            index      <= 3'd0;
            line       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            // Loading the live switch value means a start held through reset is not a rise.
            start_prev <= start_req;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            start_prev <= start_req;
            done       <= 1'b0;
            case (state)
                S_IDLE, S_STOP: begin
                    if (state == S_STOP) begin
                        done <= 1'b1;
                    end
                    state <= S_IDLE;
                    line  <= 1'b1;
                    busy  <= 1'b0;
                    index <= 3'd0;
                    if (rise) begin
                        // Data is captured only here; later switch changes do not affect the frame.
                        shreg <= din;
                        line  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par   <= ^din;
`endif
                    end
                end
                S_START: begin
                    line  <= shreg[0];
                    shreg <= shreg >> 1;
                    index <= 3'd0;
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (index == LAST_IDX) begin
                        index <= 3'd0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        line  <= par;
                        state <= S_PARITY;
`else
                        line  <= 1'b1;
                        state <= S_STOP;
`endif
                    end else begin
                        index <= index + 3'd1;
                        line  <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                S_PARITY: begin
                    line  <= 1'b1;
                    state <= S_STOP;
                end
`endif
                default: begin
                    state <= S_IDLE;
                    line  <= 1'b1;
                    busy  <= 1'b0;
                    index <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_serial_frame_tx;

    localparam int DW = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Edges from the launching edge until done is shown.
    localparam int FL = DW + 2 + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx_if bus();

    serial_frame_tx #(.DATA_W(DW)) dut (
        .KEY (clk),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;   // bit j = line after launch edge + j (no-parity frame)
        logic       par;
    } vec_t;

    vec_t tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: j counts edges after the edge that accepted the start.
    function automatic logic m_line(input logic [7:0] d, input int j);
        if (j == 0)                   return 1'b0;
        if (j <= DW)                  return d[j-1];
        if (PAR == 1 && j == DW + 1)  return ^d;
        return 1'b1;
    endfunction

    function automatic logic m_busy(input int j);
        return (j < FL);
    endfunction

    function automatic logic m_done(input int j);
        return (j == FL);
    endfunction

    function automatic logic [2:0] m_idx(input int j);
        if (j >= 1 && j <= DW) return 3'(j - 1);
        return 3'd0;
    endfunction

    function automatic logic tab_line(input vec_t e, input int j);
        if (j <= DW || (PAR == 0 && j == DW + 1)) return e.seq[j];
        if (PAR == 1 && j == DW + 1)              return e.par;
        return 1'b1;
    endfunction

    task automatic check_edge(input string tag, input logic [7:0] d, input int j);
        check({tag, "_line"}, bus.LEDR[0],   m_line(d, j));
        check({tag, "_busy"}, bus.LEDR[9],   m_busy(j));
        check({tag, "_done"}, bus.LEDR[8],   m_done(j));
        check({tag, "_idx"},  bus.LEDR[3:1], m_idx(j));
        check({tag, "_zero"}, bus.LEDR[7:4], 4'h0);
    endtask

    task automatic launch(input logic [7:0] d);
        bus.SW[8] = 1'b0;
        tick();
        bus.SW[7:0] = d;
        bus.SW[8]   = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] d2;

        tab[0] = '{data: 8'hA5, seq: 10'h34A, par: 1'b0};
        tab[1] = '{data: 8'h07, seq: 10'h20E, par: 1'b1};
        tab[2] = '{data: 8'h00, seq: 10'h200, par: 1'b0};
        tab[3] = '{data: 8'hFF, seq: 10'h3FE, par: 1'b0};
        tab[4] = '{data: 8'h80, seq: 10'h300, par: 1'b1};
        tab[5] = '{data: 8'h01, seq: 10'h202, par: 1'b1};

        // Reset with start held, then release with start still high: no frame.
        bus.SW = 10'h300;
        tick();
        tick();
        check("reset_state", bus.LEDR, 10'h001);
        bus.SW[9] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_start_no_frame", bus.LEDR, 10'h001);
        end

        // Table-driven frames.
        for (int t = 0; t < 6; t++) begin
            launch(tab[t].data);
            for (int j = 0; j <= FL + 1; j++) begin
                if (j > 0) tick();
                check("tab_line", bus.LEDR[0], tab_line(tab[t], j));
                check("tab_busy", bus.LEDR[9], m_busy(j));
                check("tab_done", bus.LEDR[8], m_done(j));
            end
        end

        // Switch data changed mid-frame: the latched word keeps going out.
        launch(8'hA5);
        for (int j = 0; j <= FL + 1; j++) begin
            if (j > 0) tick();
            check_edge("midchg", 8'hA5, j);
            if (j == 2) bus.SW[7:0] = 8'h00;
        end

        // Start toggled during DATA: ignored, no second frame.
        launch(8'h3C);
        for (int j = 0; j <= FL + 4; j++) begin
            if (j > 0) tick();
            check_edge("busyrise", 8'h3C, j);
            if (j == 2) bus.SW[8] = 1'b0;
            if (j == 4) bus.SW[8] = 1'b1;
        end

        // Rise on the done edge: new start bit on that same edge.
        d  = 8'h5A;
        d2 = 8'hC3;
        launch(d);
        for (int j = 0; j < FL; j++) begin
            if (j > 0) tick();
            check_edge("chain1", d, j);
            if (j == FL - 2) bus.SW[8] = 1'b0;
            if (j == FL - 1) begin
                bus.SW[8]   = 1'b1;
                bus.SW[7:0] = d2;
            end
        end
        tick();
        check("chain_done", bus.LEDR[8], 1'b1);
        check("chain_busy", bus.LEDR[9], 1'b1);
        check("chain_start", bus.LEDR[0], 1'b0);
        for (int j = 1; j <= FL + 1; j++) begin
            tick();
            check_edge("chain2", d2, j);
        end

        // Reset at data bit 3: frame abandoned, no stop or done afterwards.
        launch(8'h96);
        for (int j = 0; j <= 3; j++) begin
            if (j > 0) tick();
            check_edge("rstmid", 8'h96, j);
        end
        bus.SW[9] = 1'b1;
        tick();
        check("rstmid_after", bus.LEDR, 10'h001);
        bus.SW[9] = 1'b0;
        for (int i = 0; i < FL + 2; i++) begin
            tick();
            check("rstmid_quiet", bus.LEDR, 10'h001);
        end

        // Randomized frames with switch noise that must be ignored.
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom_range(0, 255));
            launch(d);
            for (int j = 0; j <= FL + 1; j++) begin
                if (j > 0) tick();
                check_edge("rand", d, j);
                if (j >= 1) bus.SW[7:0] = 8'($urandom);
                if (j >= 1 && j <= DW - 2) bus.SW[8] = 1'($urandom);
                if (j == DW - 1) bus.SW[8] = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
